// File: rtl/atm_ledger_arbiter.sv
// Round-robin arbiter and read-modify-write sequencer for a shared ATM account balance.
// Each transaction takes IDLE -> GRANT -> DONE; the winner's request is latched in IDLE.
module atm_ledger_arbiter #(
    parameter int N_TERM       = 4,
    parameter int AMT_W        = 16,
    parameter int LARGE_LIMIT  = 10000,
    parameter int INIT_BALANCE = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_TERM-1:0]       req,
    input  logic [2*N_TERM-1:0]     op,
    input  logic [AMT_W*N_TERM-1:0] amt,
    input  logic [N_TERM-1:0]       face_ok,
    output logic [N_TERM-1:0]       gnt,
    output logic [N_TERM-1:0]       done,
    output logic [1:0]              status,
    output logic [AMT_W-1:0]        resp_balance,
    output logic [AMT_W-1:0]        balance,
    output logic [7:0]              txn_count,
    output logic                    busy
);

    localparam int PTR_W = (N_TERM > 1) ? $clog2(N_TERM) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [1:0]        op_q, op_d;
    logic [AMT_W-1:0]  amt_q, amt_d;
    logic              face_q, face_d;
    logic [N_TERM-1:0] gnt_q, gnt_d;
    logic [N_TERM-1:0] done_q, done_d;
    logic [1:0]        status_q, status_d;
    logic [AMT_W-1:0]  resp_q, resp_d;
    logic [AMT_W-1:0]  bal_q, bal_d;
    logic [7:0]        txn_q, txn_d;

    logic [PTR_W-1:0]  sel;
    logic              found;
    int                rr_idx;
    logic [AMT_W:0]    sum;
    logic              txn_ok;

    // Round-robin search starting at the pointer; the first requester found wins.
    always_comb begin
        sel    = '0;
        found  = 1'b0;
        rr_idx = 0;
        for (int i = 0; i < N_TERM; i++) begin
            rr_idx = (int'(ptr_q) + i) % N_TERM;
            if (!found && req[rr_idx]) begin
                found = 1'b1;
                sel   = PTR_W'(rr_idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        op_d     = op_q;
        amt_d    = amt_q;
        face_d   = face_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        status_d = status_q;
        resp_d   = resp_q;
        bal_d    = bal_q;
        txn_d    = txn_q;
        txn_ok   = 1'b0;
        sum      = {1'b0, bal_q} + {1'b0, amt_q};

        case (state_q)
            IDLE: begin
                if (found) begin
                    op_d    = op[2*sel +: 2];
                    amt_d   = amt[AMT_W*sel +: AMT_W];
                    face_d  = face_ok[sel];
                    gnt_d   = N_TERM'(1) << sel;
                    ptr_d   = (sel == PTR_W'(N_TERM - 1)) ? '0 : sel + 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                status_d = 2'b00;
                case (op_q)
                    2'b01: begin
                        if (sum[AMT_W]) begin
                            status_d = 2'b10;
                        end else begin
                            bal_d  = sum[AMT_W-1:0];
                            txn_ok = 1'b1;
                        end
                    end
                    2'b10: begin
                        // Face check outranks the funds check so a large request never leaks the balance.
                        if ((amt_q > AMT_W'(LARGE_LIMIT)) && !face_q) begin
                            status_d = 2'b11;
                        end else if (amt_q > bal_q) begin
                            status_d = 2'b01;
                        end else begin
                            bal_d  = bal_q - amt_q;
                            txn_ok = 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (txn_ok && (txn_q != 8'hFF)) begin
                    txn_d = txn_q + 8'd1;
                end
                resp_d  = bal_d;
                done_d  = gnt_q;
                state_d = DONE;
            end
            DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            op_q     <= 2'b00;
            amt_q    <= '0;
            face_q   <= 1'b0;
            gnt_q    <= '0;
            done_q   <= '0;
            status_q <= 2'b00;
            resp_q   <= '0;
            bal_q    <= AMT_W'(INIT_BALANCE);
            txn_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            op_q     <= op_d;
            amt_q    <= amt_d;
            face_q   <= face_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            status_q <= status_d;
            resp_q   <= resp_d;
            bal_q    <= bal_d;
            txn_q    <= txn_d;
        end
    end

    assign gnt          = gnt_q;
    assign done         = done_q;
    assign status       = status_q;
    assign resp_balance = resp_q;
    assign balance      = bal_q;
    assign txn_count    = txn_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Directed bench for atm_ledger_arbiter: single-terminal ops, limits, round-robin fairness
// and an abort by reset while a withdrawal is in flight.
module tb_atm_ledger_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [63:0] amt;
    logic [3:0]  face_ok;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [1:0]  status;
    logic [15:0] resp_balance;
    logic [15:0] balance;
    logic [7:0]  txn_count;
    logic        busy;

    logic        reset2_n;
    logic [3:0]  req2;
    logic [7:0]  op2;
    logic [63:0] amt2;
    logic [3:0]  face2;
    logic [3:0]  gnt2;
    logic [3:0]  done2;
    logic [1:0]  status2;
    logic [15:0] resp2;
    logic [15:0] balance2;
    logic [7:0]  txn2;
    logic        busy2;

    int total = 0;
    int bad   = 0;

    atm_ledger_arbiter #(
        .N_TERM(4), .AMT_W(16), .LARGE_LIMIT(10000), .INIT_BALANCE(500)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .req(req), .op(op), .amt(amt), .face_ok(face_ok),
        .gnt(gnt), .done(done), .status(status), .resp_balance(resp_balance),
        .balance(balance), .txn_count(txn_count), .busy(busy)
    );

    atm_ledger_arbiter #(
        .N_TERM(4), .AMT_W(16), .LARGE_LIMIT(10000), .INIT_BALANCE(400)
    ) u_dut2 (
        .clk(clk), .reset_n(reset2_n), .req(req2), .op(op2), .amt(amt2), .face_ok(face2),
        .gnt(gnt2), .done(done2), .status(status2), .resp_balance(resp2),
        .balance(balance2), .txn_count(txn2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction from terminal t; inputs are scrambled after the sample to prove latching.
    task automatic apply_stimulus(input int t, input logic [1:0] opc, input logic [15:0] a,
                                  input logic f, input logic [1:0] exp_status,
                                  input logic [15:0] exp_bal, input logic [7:0] exp_txn);
        req        = 4'b0001 << t;
        op         = '0;
        amt        = '0;
        face_ok    = '0;
        op[2*t +: 2]   = opc;
        amt[16*t +: 16] = a;
        face_ok[t]     = f;
        step();
        check($sformatf("gnt_t%0d", t), gnt, 4'b0001 << t);
        check("busy_grant", busy, 1'b1);
        check("done_early", done, 4'b0000);
        req     = '0;
        op      = ~op;
        amt     = ~amt;
        face_ok = ~face_ok;
        step();
        check($sformatf("done_t%0d", t), done, 4'b0001 << t);
        check($sformatf("status_t%0d", t), status, exp_status);
        check("resp_balance", resp_balance, exp_bal);
        check("balance", balance, exp_bal);
        check("txn_count", txn_count, exp_txn);
        op      = '0;
        amt     = '0;
        face_ok = '0;
        step();
        check("done_clear", done, 4'b0000);
        check("gnt_clear", gnt, 4'b0000);
        check("busy_idle", busy, 1'b0);
    endtask

    initial begin
        logic [15:0] exp_bal;

        reset_n  = 1'b0;
        reset2_n = 1'b0;
        req = '0; op = '0; amt = '0; face_ok = '0;
        req2 = '0; op2 = '0; amt2 = '0; face2 = '0;
        #12;
        check("rst_balance", balance, 16'd500);
        check("rst_gnt", gnt, 4'b0000);
        check("rst_done", done, 4'b0000);
        check("rst_txn", txn_count, 8'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_resp", resp_balance, 16'd0);
        step();
        reset_n  = 1'b1;
        reset2_n = 1'b1;

        apply_stimulus(1, 2'b01, 16'd250,   1'b0, 2'b00, 16'd750,   8'd1);
        apply_stimulus(2, 2'b10, 16'd1000,  1'b0, 2'b01, 16'd750,   8'd1);
        apply_stimulus(2, 2'b10, 16'd750,   1'b0, 2'b00, 16'd0,     8'd2);
        apply_stimulus(0, 2'b01, 16'd20000, 1'b0, 2'b00, 16'd20000, 8'd3);
        apply_stimulus(0, 2'b10, 16'd15000, 1'b0, 2'b11, 16'd20000, 8'd3);
        apply_stimulus(0, 2'b10, 16'd15000, 1'b1, 2'b00, 16'd5000,  8'd4);
        apply_stimulus(0, 2'b01, 16'd5000,  1'b0, 2'b00, 16'd10000, 8'd5);
        apply_stimulus(0, 2'b10, 16'd10000, 1'b0, 2'b00, 16'd0,     8'd6);
        apply_stimulus(3, 2'b01, 16'd65000, 1'b0, 2'b00, 16'd65000, 8'd7);
        apply_stimulus(3, 2'b01, 16'd600,   1'b0, 2'b10, 16'd65000, 8'd7);
        apply_stimulus(3, 2'b01, 16'd535,   1'b0, 2'b00, 16'd65535, 8'd8);
        apply_stimulus(1, 2'b11, 16'd40,    1'b0, 2'b00, 16'd65535, 8'd8);
        apply_stimulus(2, 2'b10, 16'd0,     1'b0, 2'b00, 16'd65535, 8'd9);

        // Fresh reset puts the pointer back at terminal 0, then all four contend.
        #2;
        reset_n = 1'b0;
        #1;
        check("rst2_balance", balance, 16'd500);
        check("rst2_txn", txn_count, 8'd0);
        reset_n = 1'b1;
        req = 4'b1111;
        op  = 8'b01_01_01_01;
        amt = {16'd4, 16'd3, 16'd2, 16'd1};
        exp_bal = 16'd500;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("rr_gnt_%0d", k), gnt, 4'b0001 << (k % 4));
            exp_bal = exp_bal + 16'((k % 4) + 1);
            step();
            check($sformatf("rr_done_%0d", k), done, 4'b0001 << (k % 4));
            check($sformatf("rr_bal_%0d", k), balance, exp_bal);
            step();
            check($sformatf("rr_idle_%0d", k), done, 4'b0000);
        end
        check("rr_txn", txn_count, 8'd5);
        req = '0;

        // Reset during GRANT on the second instance must discard the withdrawal.
        req2 = 4'b0001;
        op2  = 8'b00_00_00_10;
        amt2 = {48'd0, 16'd100};
        step();
        check("abort_gnt", gnt2, 4'b0001);
        #2;
        reset2_n = 1'b0;
        #1;
        check("abort_gnt_clr", gnt2, 4'b0000);
        check("abort_busy", busy2, 1'b0);
        check("abort_balance", balance2, 16'd400);
        step();
        check("abort_no_done", done2, 4'b0000);
        check("abort_balance_hold", balance2, 16'd400);
        req2 = '0;
        reset2_n = 1'b1;
        step();
        check("abort_after_done", done2, 4'b0000);
        check("abort_after_bal", balance2, 16'd400);
        check("abort_txn", txn2, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
